// File: rtl/alu_pkg.sv
// Shared opcode encoding, command payload and issue-FSM state encoding.
package alu_pkg;

  localparam int unsigned A_W   = 4;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned CMD_W = 11;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
  localparam logic [SEL_W-1:0] OP_NOT = 3'b101;
  localparam logic [SEL_W-1:0] OP_MUL = 3'b110;
  localparam logic [SEL_W-1:0] OP_CMP = 3'b111;

  // Command as stored in the FIFO: {sel, a, b}.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [A_W-1:0]   a;
    logic [A_W-1:0]   b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU with an 8-bit result; CMP returns {gt, eq}.
module alu
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // Opcode decode.
  always_comb begin
    y = '0;
    case (sel)
      OP_ADD:  y = 8'(a) + 8'(b);
      OP_SUB:  y = 8'(a) - 8'(b);
      OP_AND:  y = {4'b0, a & b};
      OP_OR:   y = {4'b0, a | b};
      OP_XOR:  y = {4'b0, a ^ b};
      OP_NOT:  y = {4'b0, ~a};
      OP_MUL:  y = 8'(a) * 8'(b);
      OP_CMP:  y = {6'b0, (a > b), (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push into full and pop from empty are ignored.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = CMD_W,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next storage, pointers (natural power-of-two wrap) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Buffers ALU commands, issues them one at a time and holds each result until taken.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [3:0]    s_a,
  input  logic [3:0]    s_b,
  input  logic [2:0]    s_sel,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [7:0]    alu_y,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_y,
  output logic [2:0]    m_sel,
  output logic [LW-1:0] level
);

  state_e     state_q, state_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_y_q, m_y_d;
  logic [2:0] m_sel_q, m_sel_d;

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty, fifo_push_c, fifo_pop_c;

  assign push_cmd    = '{sel: s_sel, a: s_a, b: s_b};
  assign s_ready     = ~fifo_full;
  assign fifo_push_c = s_valid & ~fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_c),
    .din   (push_cmd),
    .pop   (fifo_pop_c),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Issue FSM: pop/load operands, give the ALU a cycle, then hold the result.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    m_valid_d  = m_valid_q;
    m_y_d      = m_y_q;
    m_sel_d    = m_sel_q;
    fifo_pop_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          alu_a_d    = head_cmd.a;
          alu_b_d    = head_cmd.b;
          alu_sel_d  = head_cmd.sel;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        m_y_d     = alu_y;
        m_sel_d   = alu_sel_q;
        m_valid_d = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            alu_a_d    = head_cmd.a;
            alu_b_d    = head_cmd.b;
            alu_sel_d  = head_cmd.sel;
            state_d    = ST_CAPTURE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      m_valid_q <= 1'b0;
      m_y_q     <= '0;
      m_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      m_valid_q <= m_valid_d;
      m_y_q     <= m_y_d;
      m_sel_q   <= m_sel_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign m_valid = m_valid_q;
  assign m_y     = m_y_q;
  assign m_sel   = m_sel_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue driving the alu.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [3:0]    s_a, s_b;
  logic [2:0]    s_sel;
  logic [3:0]    alu_a, alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_y;
  logic          m_valid, m_ready;
  logic [7:0]    m_y;
  logic [2:0]    m_sel;
  logic [LW-1:0] level;

  typedef struct {
    logic [7:0] y;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hs_cyc[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pushes      = 0;
  int   cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .y   (alu_y)
  );

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .s_sel   (s_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_y   (alu_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y     (m_y),
    .m_sel   (m_sel),
    .level   (level)
  );

  // Reference ALU result from plain integer arithmetic, truncated to 8 bits.
  function automatic logic [7:0] alu_ref(input int a, input int b, input int sel);
    int r;
    case (sel)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = 15 - a;
      6:       r = a * b;
      default: r = ((a > b) ? 2 : 0) + ((a == b) ? 1 : 0);
    endcase
    return 8'(r & 255);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; records every command the DUT will accept at the next edge.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] sel, input logic mr);
    @(negedge clk);
    rst = r; s_valid = v; s_a = a; s_b = b; s_sel = sel; m_ready = mr;
    #1;
    if (r) begin
      exp_q.delete();
    end else if (v && s_ready) begin
      exp_q.push_back('{y: alu_ref(int'(a), int'(b), int'(sel)), sel: sel});
      pushes++;
    end
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, mr);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_y"},     int'(m_y), 0);
    check({tag, "_m_sel"},   int'(m_sel), 0);
    check({tag, "_alu_a"},   int'(alu_a), 0);
    check({tag, "_alu_b"},   int'(alu_b), 0);
    check({tag, "_alu_sel"}, int'(alu_sel), 0);
    check({tag, "_level"},   int'(level), 0);
    check({tag, "_s_ready"}, int'(s_ready), 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1'b1);
      n++;
    end
    repeat (3) idle(1'b1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Single command 6+3: popped one edge after acceptance, valid the edge after that.
  task automatic single_cmd(input string tag);
    step(1'b0, 1'b1, 4'd6, 4'd3, OP_ADD, 1'b1);
    idle(1'b1);
    check({tag, "_e0_m_valid"}, int'(m_valid), 0);
    check({tag, "_e0_level"},   int'(level), 1);
    idle(1'b1);
    check({tag, "_e1_m_valid"}, int'(m_valid), 0);
    check({tag, "_e1_level"},   int'(level), 0);
    check({tag, "_e1_alu_a"},   int'(alu_a), 6);
    check({tag, "_e1_alu_b"},   int'(alu_b), 3);
    check({tag, "_e1_alu_sel"}, int'(alu_sel), 0);
    idle(1'b1);
    check({tag, "_e2_m_valid"}, int'(m_valid), 1);
    check({tag, "_e2_m_y"},     int'(m_y), 9);
    check({tag, "_e2_m_sel"},   int'(m_sel), 0);
    drain(tag);
  endtask

  // Monitor: every output handshake pops the scoreboard and compares.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got m_y=%0d m_sel=%0d, expected no result", m_y, m_sel);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_m_y", int'(m_y), int'(mon_e.y));
        check("sb_m_sel", int'(m_sel), int'(mon_e.sel));
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] b2b_sel [5];
    int         p0;
    b2b_sel = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL};
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_sel = '0; m_ready = 1'b0;

    // Reset values.
    step(1'b1, 1'b1, 4'd1, 4'd1, 3'd0, 1'b0);
    step(1'b1, 1'b1, 4'd1, 4'd1, 3'd0, 1'b0);
    idle(1'b0);
    check_reset_state("reset");

    single_cmd("single");

    // Back-to-back with downstream always ready.
    hs_cyc.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd6, 4'd3, b2b_sel[i], 1'b1);
    drain("b2b");
    check("b2b_count", hs_cyc.size(), 5);
    if (hs_cyc.size() == 5)
      for (int i = 1; i < 5; i++) check("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 2);

    // Fill while stalled: five accepted, the sixth refused.
    p0 = pushes;
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 4'(i + 1), 4'(i + 2), 3'(i), 1'b0);
    step(1'b0, 1'b1, 4'd9, 4'd9, OP_XOR, 1'b0);
    check("fill_s_ready", int'(s_ready), 0);
    check("fill_level", int'(level), 4);
    check("fill_accepted", pushes - p0, 5);
    check("fill_m_valid", int'(m_valid), 1);
    idle(1'b1);
    check("fill_release_s_ready", int'(s_ready), 0);
    idle(1'b1);
    check("fill_after_pop_level", int'(level), 3);
    check("fill_after_pop_s_ready", int'(s_ready), 1);
    drain("fill");

    // Simultaneous push and pop at level 2.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'(3 * i + 1), 4'd5, 3'(i + 4), 1'b0);
    idle(1'b0);
    check("simul_pre_level", int'(level), 2);
    check("simul_pre_m_valid", int'(m_valid), 1);
    step(1'b0, 1'b1, 4'd15, 4'd15, OP_CMP, 1'b1);
    idle(1'b1);
    check("simul_level", int'(level), 2);
    drain("simul");

    // Reset while holding a result with three commands queued.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i + 7), 4'(i), 3'(i), 1'b0);
    idle(1'b0);
    check("rsthold_pre_level", int'(level), 3);
    check("rsthold_pre_m_valid", int'(m_valid), 1);
    step(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    idle(1'b0);
    check_reset_state("rsthold");
    single_cmd("rsthold_single");

    // Stall stability with a second command waiting.
    step(1'b0, 1'b1, 4'd5, 4'd7, OP_MUL, 1'b0);
    step(1'b0, 1'b1, 4'd2, 4'd2, OP_SUB, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      check("stall_m_valid", int'(m_valid), 1);
      check("stall_m_y", int'(m_y), 35);
      check("stall_m_sel", int'(m_sel), int'(OP_MUL));
      check("stall_alu_a", int'(alu_a), 5);
      check("stall_alu_b", int'(alu_b), 7);
      check("stall_alu_sel", int'(alu_sel), int'(OP_MUL));
    end
    check("stall_level", int'(level), 1);
    drain("stall");

    // Randomized traffic with alternating light and heavy backpressure.
    for (int i = 0; i < 1500; i++) begin
      logic mr;
      if ((i / 100) % 2 == 0) mr = ($urandom_range(0, 3) != 0);
      else                    mr = ($urandom_range(0, 4) == 0);
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom), mr);
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
